hazard_scoreboard: RTL and testbench



---
 rtl/hazard_scoreboard_pkg.sv | 61 ++++++
 rtl/hazard_scoreboard_if.sv | 37 +++
 rtl/hazard_scoreboard_decode.sv | 87 ++++++++
 rtl/hazard_scoreboard.sv | 170 +++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the decode-stage hazard scoreboard: instruction
// field positions, opcode/funct constants, producer classes and the
// forward-select encoding consumed by the decode-stage operand muxes.
package hazard_scoreboard_pkg;

    // Architectural register specifier width as carried in the instruction.
    localparam int REG_W = 5;

    // Tuse value for an operand the instruction does not read; larger than
    // any Tnew, so it can never raise a stall.
    localparam int TUSE_NONE = 3;

    // Primary opcodes.
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2b;

    // Function codes under OP_SPECIAL.
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;

    // Producer class of an in-flight destination. It decides which
    // pipeline register can supply the value once its Tnew reaches zero.
    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_ALU  = 2'd1,
        CLS_MEM  = 2'd2,
        CLS_LINK = 2'd3
    } cls_e;

    // Forward-select encoding driven to the decode-stage operand muxes.
    typedef enum logic [2:0] {
        FWD_RF    = 3'd0,
        FWD_PC8_E = 3'd1,
        FWD_ALU_M = 3'd2,
        FWD_WD_W  = 3'd3
    } fwd_e;

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[31:26];
    endfunction

    function automatic logic [5:0] funct_of(input logic [31:0] instr);
        return instr[5:0];
    endfunction

    function automatic logic [REG_W-1:0] rs_of(input logic [31:0] instr);
        return instr[25:21];
    endfunction

    function automatic logic [REG_W-1:0] rt_of(input logic [31:0] instr);
        return instr[20:16];
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-stage forwarding interface between the decode stage (master) and
// the hazard scoreboard (slave). With HAZARD_STAT_EN defined the interface
// also carries the stall and forward statistics counters.
//
// There is no valid/ready handshake: the decode stage presents Instr_D and
// A3_D every cycle, and holds them unchanged for as long as Stall is high;
// the scoreboard answers combinationally in the same cycle.
interface hazard_scoreboard_if;

    logic [31:0] Instr_D;
    logic [4:0]  A3_D;
    logic        ext_stall;
    logic        Stall;
    logic [2:0]  ForwardRSD;
    logic [2:0]  ForwardRTD;
`ifdef HAZARD_STAT_EN
    logic [31:0] stall_cnt;
    logic [31:0] fwd_cnt;
`endif

    modport master (
        output Instr_D, A3_D, ext_stall,
`ifdef HAZARD_STAT_EN
        input  stall_cnt, fwd_cnt,
`endif
        input  Stall, ForwardRSD, ForwardRTD
    );

    modport slave (
        input  Instr_D, A3_D, ext_stall,
`ifdef HAZARD_STAT_EN
        output stall_cnt, fwd_cnt,
`endif
        output Stall, ForwardRSD, ForwardRTD
    );

endinterface

// File: rtl/hazard_scoreboard_decode.sv
// tuse_tnew_decode: purely combinational classification of the instruction
// in decode. Produces the cycle each source operand is first needed (Tuse),
// the cycles until its result exists once it enters E (Tnew) and its
// producer class. Unknown encodings read nothing and write nothing.
module tuse_tnew_decode
    import hazard_scoreboard_pkg::*;
#(
    parameter int TW = 2
) (
    input  logic [31:0]   instr,
    output logic [TW-1:0] tuse_rs,
    output logic [TW-1:0] tuse_rt,
    output logic [TW-1:0] tnew,
    output cls_e          cls
);

    localparam logic [TW-1:0] T0 = '0;
    localparam logic [TW-1:0] T1 = TW'(1);
    localparam logic [TW-1:0] T2 = TW'(2);
    localparam logic [TW-1:0] TN = TW'(TUSE_NONE);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode        = opcode_of(instr);
    assign funct         = funct_of(instr);
    // Register and immediate fields are resolved by the scoreboard itself.
    assign unused_fields = ^instr[25:6];

    // Opcode/funct table: operand timing and result class.
    always_comb begin
        tuse_rs = TN;
        tuse_rt = TN;
        tnew    = T0;
        cls     = CLS_NONE;
        case (opcode)
            OP_SPECIAL: begin
                case (funct)
                    FN_ADDU, FN_SUBU: begin
                        tuse_rs = T1;
                        tuse_rt = T1;
                        tnew    = T1;
                        cls     = CLS_ALU;
                    end
                    FN_JR: begin
                        tuse_rs = T0;
                    end
                    default: begin
                    end
                endcase
            end
            OP_ORI: begin
                tuse_rs = T1;
                tnew    = T1;
                cls     = CLS_ALU;
            end
            OP_LUI: begin
                tnew = T1;
                cls  = CLS_ALU;
            end
            OP_LW: begin
                tuse_rs = T1;
                tnew    = T2;
                cls     = CLS_MEM;
            end
            OP_SW: begin
                tuse_rs = T1;
                tuse_rt = T2;
            end
            OP_BEQ: begin
                tuse_rs = T0;
                tuse_rt = T0;
            end
            OP_JAL: begin
                // Link value PC+8 exists as soon as jal reaches E.
                tnew = T0;
                cls  = CLS_LINK;
            end
            OP_J: begin
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: producer side of the decode-stage forwarding interface.
// Tracks the destinations of the instructions in E, M and W in a shadow
// pipeline with per-slot Tnew, and compares them against the Tuse of the
// instruction in decode to produce Stall and the rs/rt forward selects.
// All outputs are combinational from the shadow slots plus Instr_D and
// ext_stall.
//
// Optional build macro HAZARD_STAT_EN: adds the stall_cnt / fwd_cnt
// statistics counters to the interface.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int TW       = 2
) (
    input  logic           clk,
    input  logic           reset,
    hazard_scoreboard_if.slave hz
);

    localparam int RW = $clog2(NUM_REGS);
    localparam logic [TW-1:0] TUSE_N = TW'(TUSE_NONE);

    // One in-flight destination; a3 == 0 marks an empty slot, because
    // register 0 never needs forwarding.
    typedef struct packed {
        logic [RW-1:0] a3;
        logic [TW-1:0] tnew;
        cls_e          cls;
    } slot_t;

    // Per-operand verdict: stall request and forward select.
    typedef struct packed {
        logic hzd;
        fwd_e sel;
    } opnd_t;

    logic [TW-1:0] tuse_rs;
    logic [TW-1:0] tuse_rt;
    logic [TW-1:0] tnew_d;
    cls_e          cls_d;
    logic [RW-1:0] rs_d;
    logic [RW-1:0] rt_d;
    slot_t         e_q;
    slot_t         m_q;
    slot_t         w_q;
    opnd_t         rs_res;
    opnd_t         rt_res;
    logic          hazard;
    logic          stall;

    tuse_tnew_decode #(
        .TW(TW)
    ) u_decode (
        .instr   (hz.Instr_D),
        .tuse_rs (tuse_rs),
        .tuse_rt (tuse_rt),
        .tnew    (tnew_d),
        .cls     (cls_d)
    );

    assign rs_d = RW'(rs_of(hz.Instr_D));
    assign rt_d = RW'(rt_of(hz.Instr_D));

    // Only the youngest matching slot counts: an older write to the same
    // register is stale. The value is forwardable only once Tnew is zero,
    // and only from a stage whose result mux actually carries it (E only
    // holds PC+8 for a link). Operands the instruction does not read
    // (Tuse = none) are ignored entirely, so fields such as the rt of
    // lui/ori/lw, which name the destination, never produce a select.
    function automatic opnd_t resolve(input logic [RW-1:0] r,
                                      input logic [TW-1:0] tuse,
                                      input slot_t         e,
                                      input slot_t         m,
                                      input slot_t         w);
        opnd_t res;
        res.hzd = 1'b0;
        res.sel = FWD_RF;
        if (r != '0 && tuse != TUSE_N) begin
            if (e.a3 == r) begin
                res.hzd = (e.tnew > tuse);
                if (e.tnew == '0 && e.cls == CLS_LINK) begin
                    res.sel = FWD_PC8_E;
                end
            end else if (m.a3 == r) begin
                res.hzd = (m.tnew > tuse);
                if (m.tnew == '0 && (m.cls == CLS_ALU || m.cls == CLS_LINK)) begin
                    res.sel = FWD_ALU_M;
                end
            end else if (w.a3 == r) begin
                res.hzd = (w.tnew > tuse);
                if (w.tnew == '0) begin
                    res.sel = FWD_WD_W;
                end
            end
        end
        return res;
    endfunction

    // rs and rt are resolved independently against the same slots.
    always_comb begin
        rs_res = resolve(rs_d, tuse_rs, e_q, m_q, w_q);
        rt_res = resolve(rt_d, tuse_rt, e_q, m_q, w_q);
    end

    assign hazard        = rs_res.hzd | rt_res.hzd;
    assign stall         = hz.ext_stall | hazard;
    assign hz.Stall      = stall;
    assign hz.ForwardRSD = rs_res.sel;
    assign hz.ForwardRTD = rt_res.sel;

    // One cycle of progress: Tnew drops by one entering M (never below
    // zero), and every result is available by the time it reaches W.
    function automatic slot_t age_into_m(input slot_t s);
        slot_t r;
        r      = s;
        r.tnew = (s.tnew == '0) ? '0 : s.tnew - TW'(1);
        return r;
    endfunction

    function automatic slot_t age_into_w(input slot_t s);
        slot_t r;
        r      = s;
        r.tnew = '0;
        return r;
    endfunction

    // Shadow pipeline advance; a stalled decode sends a bubble into E.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            if (stall) begin
                e_q <= '0;
            end else begin
                e_q.a3   <= RW'(hz.A3_D);
                e_q.tnew <= tnew_d;
                e_q.cls  <= cls_d;
            end
            m_q <= age_into_m(e_q);
            w_q <= age_into_w(m_q);
        end
    end

`ifdef HAZARD_STAT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] fwd_cnt_q;

    // Statistics: hazard-caused stall cycles and cycles with any forward.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (hazard) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (rs_res.sel != FWD_RF || rt_res.sel != FWD_RF) begin
                fwd_cnt_q <= fwd_cnt_q + 32'd1;
            end
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard. The reference model keeps a
// short history of issued instructions (by age since entering E) and
// derives stall/forward outcomes from each instruction's result latency and
// operand need. Directed sequences carry hand-computed pins that also
// constrain the model; a short random tail widens coverage.
module tb_hazard_scoreboard;

    typedef enum logic [3:0] {
        I_NOP, I_ADDU, I_SUBU, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL, I_JR
    } op_e;

    typedef struct packed {
        logic [4:0] dst;
        op_e        op;
    } inflight_t;

    typedef struct packed {
        logic       hz;
        logic       stall;
        logic [2:0] fsd;
        logic [2:0] fst;
    } m_out_t;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    hazard_scoreboard_if hz_if ();

    hazard_scoreboard #(
        .NUM_REGS(32),
        .TW(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz_if)
    );

    // ---------------- bench state ----------------
    int         checks = 0;
    int         errors = 0;
    logic       started = 1'b0;
    op_e        cur_op = I_NOP;
    logic [4:0] cur_rs = '0;
    logic [4:0] cur_rt = '0;
    logic [4:0] cur_dst = '0;
    logic       cur_ext = 1'b0;
    logic [6:0] exp_q[$];
    inflight_t  hist[3];
`ifdef HAZARD_STAT_EN
    logic [31:0] m_stall_cnt;
    logic [31:0] m_fwd_cnt;
`endif

    // ---------------- instruction helpers ----------------
    function automatic logic [31:0] enc(input op_e op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
        case (op)
            I_ADDU:  return {6'h00, rs, rt, rd, 5'h00, 6'h21};
            I_SUBU:  return {6'h00, rs, rt, rd, 5'h00, 6'h23};
            I_ORI:   return {6'h0d, rs, rt, 16'h00ff};
            I_LUI:   return {6'h0f, 5'h00, rt, 16'h1234};
            I_LW:    return {6'h23, rs, rt, 16'h0000};
            I_SW:    return {6'h2b, rs, rt, 16'h0004};
            I_BEQ:   return {6'h04, rs, rt, 16'h0008};
            I_J:     return {6'h02, 26'h0000010};
            I_JAL:   return {6'h03, 26'h0000020};
            I_JR:    return {6'h00, rs, 15'h0000, 6'h08};
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [4:0] dst_of(input op_e op, input logic [4:0] rt,
                                          input logic [4:0] rd);
        case (op)
            I_ADDU, I_SUBU:      return rd;
            I_ORI, I_LUI, I_LW:  return rt;
            I_JAL:               return 5'd31;
            default:             return 5'd0;
        endcase
    endfunction

    // Cycle (0 = first cycle of operand use in E-relative terms) by which
    // the operand must be available; 3 means never read.
    function automatic int need_rs(input op_e op);
        case (op)
            I_BEQ, I_JR:                  return 0;
            I_ADDU, I_SUBU, I_ORI, I_LW, I_SW: return 1;
            default:                      return 3;
        endcase
    endfunction

    function automatic int need_rt(input op_e op);
        case (op)
            I_BEQ:          return 0;
            I_ADDU, I_SUBU: return 1;
            I_SW:           return 2;
            default:        return 3;
        endcase
    endfunction

    // Cycles after entering E until the result exists.
    function automatic int latency(input op_e op);
        case (op)
            I_ADDU, I_SUBU, I_ORI, I_LUI: return 1;
            I_LW:                         return 2;
            default:                      return 0;
        endcase
    endfunction

    // Where a ready value can be picked up, by age since entering E.
    function automatic logic [2:0] source_at(input op_e op, input int age);
        if (age == 0) return (op == I_JAL) ? 3'd1 : 3'd0;
        if (age == 1) return (op == I_JAL || latency(op) == 1) ? 3'd2 : 3'd0;
        return 3'd3;
    endfunction

    function automatic void judge(input logic [4:0] r, input int need,
                                  output logic hz, output logic [2:0] sel);
        logic found;
        hz    = 1'b0;
        sel   = 3'd0;
        found = 1'b0;
        if (r != 5'd0 && need != 3) begin
            for (int a = 0; a < 3; a++) begin
                if (!found && hist[a].dst == r) begin
                    int remaining;
                    found     = 1'b1;
                    remaining = latency(hist[a].op) - a;
                    if (remaining < 0) remaining = 0;
                    hz  = (remaining > need);
                    sel = (remaining == 0) ? source_at(hist[a].op, a) : 3'd0;
                end
            end
        end
    endfunction

    function automatic m_out_t model_eval(input op_e op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic ext);
        m_out_t o;
        logic   hz_s;
        logic   hz_t;
        judge(rs, need_rs(op), hz_s, o.fsd);
        judge(rt, need_rt(op), hz_t, o.fst);
        o.hz    = hz_s | hz_t;
        o.stall = o.hz | ext;
        return o;
    endfunction

    // ---------------- model state advance ----------------
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int a = 0; a < 3; a++) hist[a] <= '{dst: 5'd0, op: I_NOP};
`ifdef HAZARD_STAT_EN
            m_stall_cnt <= '0;
            m_fwd_cnt   <= '0;
`endif
        end else begin
            m_out_t mo;
            mo = model_eval(cur_op, cur_rs, cur_rt, cur_ext);
`ifdef HAZARD_STAT_EN
            if (mo.hz) m_stall_cnt <= m_stall_cnt + 32'd1;
            if (mo.fsd != 3'd0 || mo.fst != 3'd0) m_fwd_cnt <= m_fwd_cnt + 32'd1;
`endif
            hist[2] <= hist[1];
            hist[1] <= hist[0];
            hist[0] <= mo.stall ? '{dst: 5'd0, op: I_NOP} : '{dst: cur_dst, op: cur_op};
        end
    end

    // ---------------- scoreboard / compare ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always begin
        @(negedge clk or posedge reset);
        #1;
        if (started) begin
            m_out_t     m;
            logic [6:0] dut_v;
            logic [6:0] pin;
            m     = model_eval(cur_op, cur_rs, cur_rt, cur_ext);
            dut_v = {hz_if.Stall, hz_if.ForwardRSD, hz_if.ForwardRTD};
            check("stall", 32'(hz_if.Stall), 32'(m.stall));
            check("fwd_rs", 32'(hz_if.ForwardRSD), 32'(m.fsd));
            check("fwd_rt", 32'(hz_if.ForwardRTD), 32'(m.fst));
            if (exp_q.size() > 0) begin
                pin = exp_q.pop_front();
                check("pin_model", 32'({m.stall, m.fsd, m.fst}), 32'(pin));
                check("pin_dut", 32'(dut_v), 32'(pin));
            end
`ifdef HAZARD_STAT_EN
            check("stall_cnt", hz_if.stall_cnt, m_stall_cnt);
            check("fwd_cnt", hz_if.fwd_cnt, m_fwd_cnt);
            if (reset) begin
                check("stall_cnt_rst", hz_if.stall_cnt, 32'd0);
                check("fwd_cnt_rst", hz_if.fwd_cnt, 32'd0);
            end
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input op_e op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic ext,
                         input logic pin_en, input logic [6:0] pin);
        @(posedge clk);
        #1;
        cur_op          = op;
        cur_rs          = rs;
        cur_rt          = rt;
        cur_ext         = ext;
        cur_dst         = dst_of(op, rt, rd);
        hz_if.Instr_D   = enc(op, rs, rt, rd);
        hz_if.A3_D      = cur_dst;
        hz_if.ext_stall = ext;
        if (pin_en) exp_q.push_back(pin);
    endtask

    // Pinned step: pin = {Stall, ForwardRSD, ForwardRTD}.
    task automatic step(input op_e op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [6:0] pin);
        issue(op, rs, rt, rd, 1'b0, 1'b1, pin);
    endtask

    task automatic flush();
        for (int i = 0; i < 3; i++) step(I_NOP, 5'd0, 5'd0, 5'd0, 7'b0_000_000);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset           = 1'b1;
        hz_if.Instr_D   = '0;
        hz_if.A3_D      = '0;
        hz_if.ext_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        started = 1'b1;

        // Reset state: empty pipeline, nothing stalls or forwards.
        step(I_NOP, 5'd0, 5'd0, 5'd0, 7'b0_000_000);

        // addu $1,$2,$3 ; beq $1,$0 : stall once, then forward from M.
        step(I_ADDU, 5'd2, 5'd3, 5'd1, 7'b0_000_000);
        step(I_BEQ,  5'd1, 5'd0, 5'd0, 7'b1_000_000);
        step(I_BEQ,  5'd1, 5'd0, 5'd0, 7'b0_010_000);
        flush();

        // lw $2,0($0) ; addu $4,$2,$2 ; subu $6,$2,$0 picks lw from W.
        step(I_LW,   5'd0, 5'd2, 5'd0, 7'b0_000_000);
        step(I_ADDU, 5'd2, 5'd2, 5'd4, 7'b1_000_000);
        step(I_ADDU, 5'd2, 5'd2, 5'd4, 7'b0_000_000);
        step(I_SUBU, 5'd2, 5'd0, 5'd6, 7'b0_011_000);
        flush();

        // jal ; jr $31 takes PC8 from E ; next reader of $31 takes M.
        step(I_JAL,  5'd0,  5'd0,  5'd0, 7'b0_000_000);
        step(I_JR,   5'd31, 5'd0,  5'd0, 7'b0_001_000);
        step(I_ADDU, 5'd31, 5'd31, 5'd7, 7'b0_010_010);
        flush();

        // addu $5 ; sw $5,0($6) : rt needed late, no stall, then M forward.
        step(I_ADDU, 5'd1, 5'd2, 5'd5, 7'b0_000_000);
        step(I_SW,   5'd6, 5'd5, 5'd0, 7'b0_000_000);
        step(I_SW,   5'd6, 5'd5, 5'd0, 7'b0_000_010);
        flush();

        // Writes to $0 never match.
        step(I_ADDU, 5'd1, 5'd2, 5'd0, 7'b0_000_000);
        step(I_LW,   5'd0, 5'd0, 5'd0, 7'b0_000_000);
        step(I_BEQ,  5'd0, 5'd0, 5'd0, 7'b0_000_000);
        flush();

        // addu $8 ; lw $8 ; beq $8,$8 : youngest (lw) rules, single stall
        // for both operands, then both forward from W.
        step(I_ADDU, 5'd1, 5'd2, 5'd8, 7'b0_000_000);
        step(I_LW,   5'd0, 5'd8, 5'd0, 7'b0_000_000);
        step(I_BEQ,  5'd8, 5'd8, 5'd0, 7'b1_000_000);
        step(I_BEQ,  5'd8, 5'd8, 5'd0, 7'b1_000_000);
        step(I_BEQ,  5'd8, 5'd8, 5'd0, 7'b0_011_011);
        flush();

        // ext_stall freezes and bubbles: the addu never enters E.
        issue(I_ADDU, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 7'b1_000_000);
        step(I_BEQ,   5'd9, 5'd0, 5'd0, 7'b0_000_000);
        flush();

        // Reset in the middle of an lw-use stall.
        step(I_LW,   5'd0, 5'd3, 5'd0, 7'b0_000_000);
        step(I_ADDU, 5'd3, 5'd3, 5'd4, 7'b1_000_000);
        @(negedge clk);
        #3;
        exp_q.push_back(7'b0_000_000);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        step(I_ADDU, 5'd3, 5'd3, 5'd4, 7'b0_000_000);
        flush();

        // Random mix over a few registers, checked against the model only.
        for (int i = 0; i < 80; i++) begin
            issue(op_e'(4'($urandom_range(0, 10))),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0), 1'b0, 7'b0);
        end

        @(negedge clk);
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL pins_left: got %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
